// File: rtl/router_pkg.sv
// Shared ring-router definitions: packet geometry and header layout.
package router_pkg;

    localparam int unsigned PKT_W       = 64;
    localparam int unsigned PKT_VC_BIT  = 63;
    localparam int unsigned PKT_DIR_BIT = 62;
    localparam int unsigned HOP_LSB     = 0;
    localparam int unsigned HOP_W       = 8;
    localparam int unsigned SRC_LSB     = 8;
    localparam int unsigned SRC_W       = 8;

    typedef struct packed {
        logic              vc;
        logic              dir;
        logic [45:0]       payload;
        logic [SRC_W-1:0]  src;
        logic [HOP_W-1:0]  hop;
    } pkt_t;

endpackage

// File: rtl/lp_vc_buf.sv
// Single-entry packet buffer for one virtual channel; a write wins over a clear.
module lp_vc_buf
    import router_pkg::*;
#(
    parameter int unsigned W = PKT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         clr,
    output logic         vld,
    output logic [W-1:0] data
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (wr) begin
            vld_d  = 1'b1;
            data_d = wr_data;
        end else if (clr) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/router_local_port.sv
// PE-facing ring router port: polarity generator, two-VC injection and ejection buffers.
// Define LOCAL_PORT_STATS_EN to add saturating inj_cnt/ej_cnt packet counters.
module router_local_port
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = PKT_W,
    parameter int unsigned VC_BIT  = PKT_VC_BIT,
    parameter int unsigned DIR_BIT = PKT_DIR_BIT
) (
    input  logic              clk,
    input  logic              reset,
`ifdef LOCAL_PORT_STATS_EN
    output logic [15:0]       inj_cnt,
    output logic [15:0]       ej_cnt,
`endif
    output logic              net_polarity,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_do,
    output logic              net_si,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_di,
    output logic              cw_so,
    output logic              ccw_so,
    input  logic              cw_ro,
    input  logic              ccw_ro,
    output logic [DATA_W-1:0] cw_do,
    output logic [DATA_W-1:0] ccw_do,
    input  logic              ej_cw_si,
    input  logic              ej_ccw_si,
    input  logic [DATA_W-1:0] ej_cw_di,
    input  logic [DATA_W-1:0] ej_ccw_di,
    output logic              ej_cw_gnt,
    output logic              ej_ccw_gnt
);

    logic pol_q, pol_d;
    logic rr_q, rr_d;

    logic [1:0]        inj_wr, inj_clr, inj_vld;
    logic [1:0]        ej_wr, ej_clr, ej_vld;
    logic [DATA_W-1:0] inj_wdata, ej_wdata;
    logic [DATA_W-1:0] inj_data [2];
    logic [DATA_W-1:0] ej_data [2];
    logic              fwd_vld, fwd_fire, ri_int;
    logic [DATA_W-1:0] fwd_data;

    for (genvar i = 0; i < 2; i++) begin : g_vc
        lp_vc_buf #(.W(DATA_W)) u_inj (
            .clk     (clk),
            .rst_n   (reset),
            .wr      (inj_wr[i]),
            .wr_data (inj_wdata),
            .clr     (inj_clr[i]),
            .vld     (inj_vld[i]),
            .data    (inj_data[i])
        );
        lp_vc_buf #(.W(DATA_W)) u_ej (
            .clk     (clk),
            .rst_n   (reset),
            .wr      (ej_wr[i]),
            .wr_data (ej_wdata),
            .clr     (ej_clr[i]),
            .vld     (ej_vld[i]),
            .data    (ej_data[i])
        );
    end

    // Accepts always target VC[pol]; forwarding/delivery always drain VC[~pol].
    always_comb begin
        pol_d  = ~pol_q;

        net_ro            = ~inj_vld[pol_q];
        inj_wdata         = net_do;
        inj_wdata[VC_BIT] = pol_q;
        inj_wr            = '0;
        inj_wr[pol_q]     = net_so & net_ro;

        fwd_vld        = inj_vld[~pol_q];
        fwd_data       = inj_data[~pol_q];
        cw_so          = fwd_vld & ~fwd_data[DIR_BIT];
        ccw_so         = fwd_vld &  fwd_data[DIR_BIT];
        cw_do          = fwd_data;
        ccw_do         = fwd_data;
        fwd_fire       = (cw_so & cw_ro) | (ccw_so & ccw_ro);
        inj_clr        = '0;
        inj_clr[~pol_q] = fwd_fire;

        ri_int        = ~ej_vld[pol_q];
        ej_cw_gnt     = ej_cw_si  & ri_int & (~ej_ccw_si | ~rr_q);
        ej_ccw_gnt    = ej_ccw_si & ri_int & (~ej_cw_si  |  rr_q);
        ej_wdata      = ej_cw_gnt ? ej_cw_di : ej_ccw_di;
        ej_wr         = '0;
        ej_wr[pol_q]  = ej_cw_gnt | ej_ccw_gnt;
        rr_d          = rr_q ^ (ej_cw_si & ej_ccw_si & ri_int);

        net_si         = ej_vld[~pol_q] & net_ri;
        net_di         = ej_data[~pol_q];
        ej_clr         = '0;
        ej_clr[~pol_q] = net_si;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q <= 1'b0;
            rr_q  <= 1'b0;
        end else begin
            pol_q <= pol_d;
            rr_q  <= rr_d;
        end
    end

    assign net_polarity = pol_q;

`ifdef LOCAL_PORT_STATS_EN
    logic [15:0] inj_cnt_q, inj_cnt_d;
    logic [15:0] ej_cnt_q, ej_cnt_d;

    always_comb begin
        inj_cnt_d = inj_cnt_q;
        ej_cnt_d  = ej_cnt_q;
        if (fwd_fire && inj_cnt_q != 16'hFFFF) inj_cnt_d = inj_cnt_q + 16'd1;
        if (net_si && ej_cnt_q != 16'hFFFF)    ej_cnt_d  = ej_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_cnt_q <= '0;
            ej_cnt_q  <= '0;
        end else begin
            inj_cnt_q <= inj_cnt_d;
            ej_cnt_q  <= ej_cnt_d;
        end
    end

    assign inj_cnt = inj_cnt_q;
    assign ej_cnt  = ej_cnt_q;
`endif

endmodule
